// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: Tuse/Tnew encodings, MDU state and default latencies.
// Also holds the per-source hazard compare so every consumer applies the same rule.
package pipe_pkg;

  localparam logic [1:0] T_BRANCH = 2'd0;
  localparam logic [1:0] T_ALU    = 2'd1;
  localparam logic [1:0] T_MEM    = 2'd2;
  localparam logic [1:0] T_NONE   = 2'd3;

  localparam int LAT_MULT_DEF = 5;
  localparam int LAT_DIV_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A producer blocks a consumer only if its value arrives later than needed.
  // tuse = T_NONE can never be below any 2-bit tnew, so it never stalls.
  function automatic logic src_stall(input logic [4:0] src,
                                     input logic [1:0] tuse,
                                     input logic [4:0] wa_e,
                                     input logic [1:0] tnew_e,
                                     input logic [4:0] wa_m,
                                     input logic [1:0] tnew_m);
    logic hit_e;
    logic hit_m;
    hit_e = (src == wa_e) && (tuse < tnew_e);
    hit_m = (src == wa_m) && (tuse < tnew_m);
    return (src != 5'd0) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
interface hazard_stall_ctrl_if;

  // No valid/ready pair here: start_E is a single-cycle valid-qualified issue
  // pulse, and stall acts as backpressure on D that takes effect in the same cycle.
  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [1:0]  tuse_rs_D;
  logic [1:0]  tuse_rt_D;
  logic        md_D;
  logic [4:0]  wa_E;
  logic [4:0]  wa_M;
  logic [1:0]  tnew_E;
  logic [1:0]  tnew_M;
  logic        start_E;
  logic        is_div_E;
  logic        stall;
  logic        flush_E;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
    output wa_E, wa_M, tnew_E, tnew_M, start_E, is_div_E,
    input  stall, flush_E, md_busy, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
    input  wa_E, wa_M, tnew_E, tnew_M, start_E, is_div_E,
    output stall, flush_E, md_busy, stall_cnt
  );

endinterface

// File: rtl/mdu_busy_ctr.sv
// Multiply/divide occupancy tracker: a two-state FSM with a latency down-counter.
// A start while busy reloads the count with the new latency.
module mdu_busy_ctr
  import pipe_pkg::*;
#(
  parameter int LAT_MULT = LAT_MULT_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [CNT_W-1:0]   lat;

  assign lat  = is_div ? CNT_W'(LAT_DIV) : CNT_W'(LAT_MULT);
  assign busy = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      if (start) begin
        state_q <= MD_BUSY;
        cnt_q   <= lat;
        busy_q  <= 1'b1;
      end else if (state_q == MD_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew stall decision, MDU busy sequencing
// and a saturating stalled-cycle counter.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int LAT_MULT = LAT_MULT_DEF,
  parameter int LAT_DIV  = LAT_DIV_DEF,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  hazard_stall_ctrl_if.slave bus
);

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        stall;
  logic        md_busy;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  mdu_busy_ctr #(
    .LAT_MULT (LAT_MULT),
    .LAT_DIV  (LAT_DIV),
    .CNT_W    (CNT_W)
  ) u_mdu_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.start_E),
    .is_div (bus.is_div_E),
    .busy   (md_busy)
  );

  always_comb begin
    stall_rs = src_stall(bus.rs_D, bus.tuse_rs_D, bus.wa_E, bus.tnew_E, bus.wa_M, bus.tnew_M);
    stall_rt = src_stall(bus.rt_D, bus.tuse_rt_D, bus.wa_E, bus.tnew_E, bus.wa_M, bus.tnew_M);
    // The issuing cycle counts too: busy only rises one edge after start_E.
    stall_md = bus.md_D && (bus.start_E || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flush_E   = stall;
  assign bus.md_busy   = md_busy;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: expected {stall, flush_E, md_busy, stall_cnt}
// words are queued as each step is driven and popped when the outputs are sampled.
module tb_hazard_stall_ctrl;
  import pipe_pkg::*;

  localparam int W = 35;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0]  model_cnt;
  logic [W-1:0] exp_q[$];

  hazard_stall_ctrl_if bus();

  hazard_stall_ctrl #(
    .LAT_MULT (5),
    .LAT_DIV  (10),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    bus.rs_D      = 5'd0;
    bus.rt_D      = 5'd0;
    bus.tuse_rs_D = T_NONE;
    bus.tuse_rt_D = T_NONE;
    bus.md_D      = 1'b0;
    bus.wa_E      = 5'd0;
    bus.wa_M      = 5'd0;
    bus.tnew_E    = T_BRANCH;
    bus.tnew_M    = T_BRANCH;
    bus.start_E   = 1'b0;
    bus.is_div_E  = 1'b0;
  endtask

  // Queue the expected outputs for the current cycle and compare them now.
  task automatic chk(input string tag, input logic exp_stall, input logic exp_busy);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    exp_q.push_back({exp_stall, exp_stall, exp_busy, model_cnt});
    obs = {bus.stall, bus.flush_E, bus.md_busy, bus.stall_cnt};
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full cycle: compare mid-cycle, then advance the counter model at the edge.
  task automatic cyc(input string tag, input logic exp_stall, input logic exp_busy);
    @(negedge clk);
    chk(tag, exp_stall, exp_busy);
    @(posedge clk);
    if (exp_stall && (model_cnt != 32'hFFFF_FFFF)) model_cnt = model_cnt + 32'd1;
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_cnt = 32'd0;
    clear_inputs();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk("reset_state", 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Load-use: E load result not ready for ALU use next cycle.
    bus.rs_D = 5'd8; bus.tuse_rs_D = T_ALU; bus.wa_E = 5'd8; bus.tnew_E = T_MEM;
    cyc("load_use_stall", 1'b1, 1'b0);
    bus.wa_E = 5'd0; bus.tnew_E = T_BRANCH; bus.wa_M = 5'd8; bus.tnew_M = T_ALU;
    cyc("load_use_forward", 1'b0, 1'b0);

    // Branch consuming an ALU result still in E.
    clear_inputs();
    bus.rt_D = 5'd9; bus.tuse_rt_D = T_BRANCH; bus.wa_E = 5'd9; bus.tnew_E = T_ALU;
    cyc("branch_after_alu", 1'b1, 1'b0);
    bus.rt_D = 5'd0; bus.wa_E = 5'd0;
    cyc("reg0_never_stalls", 1'b0, 1'b0);

    // Match with tnew == tuse is forwarded; unused source never stalls.
    clear_inputs();
    bus.rs_D = 5'd4; bus.tuse_rs_D = T_ALU; bus.wa_M = 5'd4; bus.tnew_M = T_ALU;
    cyc("tnew_eq_tuse", 1'b0, 1'b0);
    bus.rs_D = 5'd4; bus.tuse_rs_D = T_NONE; bus.wa_E = 5'd4; bus.tnew_E = T_NONE;
    cyc("tuse_none", 1'b0, 1'b0);
    bus.rs_D = 5'd0; bus.rt_D = 5'd12; bus.tuse_rt_D = T_ALU; bus.wa_M = 5'd12; bus.tnew_M = T_MEM;
    cyc("rt_match_m", 1'b1, 1'b0);

    // mult at t with mflo in D: stalls t..t+5, issues t+6.
    clear_inputs();
    bus.start_E = 1'b1; bus.md_D = 1'b1;
    cyc("mult_issue", 1'b1, 1'b0);
    bus.start_E = 1'b0;
    for (int i = 1; i <= 5; i++) cyc("mult_busy", 1'b1, 1'b1);
    cyc("mflo_issue", 1'b0, 1'b0);

    // div: busy exactly 10 cycles; non-md instructions pass, md ones stall.
    clear_inputs();
    bus.start_E = 1'b1; bus.is_div_E = 1'b1;
    cyc("div_issue", 1'b0, 1'b0);
    bus.start_E = 1'b0; bus.is_div_E = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      bus.md_D = (i >= 9);
      cyc("div_busy", (i >= 9), 1'b1);
    end
    cyc("div_done", 1'b0, 1'b0);

    // start_E while busy reloads with the new latency.
    clear_inputs();
    bus.start_E = 1'b1;
    cyc("reload_mult", 1'b0, 1'b0);
    bus.start_E = 1'b0;
    cyc("reload_busy1", 1'b0, 1'b1);
    bus.start_E = 1'b1; bus.is_div_E = 1'b1;
    cyc("reload_div", 1'b0, 1'b1);
    bus.start_E = 1'b0; bus.is_div_E = 1'b0;
    for (int i = 1; i <= 10; i++) cyc("reload_busy", 1'b0, 1'b1);
    cyc("reload_done", 1'b0, 1'b0);

    // Reset during busy cycle 3 of a div clears busy and the pending stall at once.
    clear_inputs();
    bus.start_E = 1'b1; bus.is_div_E = 1'b1;
    cyc("rst_div_issue", 1'b0, 1'b0);
    bus.start_E = 1'b0; bus.is_div_E = 1'b0;
    cyc("rst_busy1", 1'b0, 1'b1);
    cyc("rst_busy2", 1'b0, 1'b1);
    bus.md_D = 1'b1;
    #1 chk("rst_busy3_stall", 1'b1, 1'b1);
    reset = 1'b0;
    model_cnt = 32'd0;
    #1 chk("rst_mid_busy", 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc("mflo_after_rst", 1'b0, 1'b0);

    // Saturation: preload near the top, then hold stall.
    clear_inputs();
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    model_cnt = 32'hFFFF_FFFD;
    bus.rs_D = 5'd3; bus.tuse_rs_D = T_BRANCH; bus.wa_E = 5'd3; bus.tnew_E = T_ALU;
    for (int i = 0; i < 5; i++) cyc("saturate", 1'b1, 1'b0);
    clear_inputs();
    cyc("saturate_hold", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller for the five-stage MIPS core. It compares D-stage source registers against in-flight E/M destinations using Tuse/Tnew timing, and decides stall-versus-forward: the forwarding muxes resolve everything except what this block stalls. It also sequences the multi-cycle multiply/divide unit through a busy counter. It drives the PC/IF-ID freeze and the ID-EX bubble, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `LAT_MULT`, 5, cycles a mult/multu occupies HI/LO after issue
- `LAT_DIV`, 10, cycles a div/divu occupies HI/LO after issue
- `CNT_W`, 4, width of busy counter; must hold max(LAT_MULT, LAT_DIV)

- `clk`  in  1  core clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `rs_D`, `rt_D`  in  5  D-stage source register numbers
- `tuse_rs_D`, `tuse_rt_D`  in  2  cycles until D instruction needs rs/rt (0 = branch/jr in D, 1 = ALU in E, 2 = store data in M); 3 = not used
- `md_D`  in  1  D instruction touches HI/LO or MDU (mult/div/mfhi/mflo/mthi/mtlo)
- `wa_E`, `wa_M`  in  5  destination register of E / M instruction (0 = none)
- `tnew_E`, `tnew_M`  in  2  cycles until that result is forwardable
- `start_E`  in  1  E instruction is mult/multu/div/divu (valid-qualified)
- `is_div_E`  in  1  with `start_E`: 1 = div/divu, 0 = mult/multu
- `stall`  out  1  freeze PC and IF/ID register
- `flush_E`  out  1  load bubble into ID/EX register
- `md_busy`  out  1  MDU result pending
- `stall_cnt`  out  32  total stalled cycles since reset, saturating

## Operation
- Data hazard, combinational: `stall_rs` = rs_D≠0 & ((rs_D==wa_E & tuse_rs_D<tnew_E) | (rs_D==wa_M & tuse_rs_D<tnew_M)); same for rt. A value of 3 in tuse never stalls. A match with tnew ≤ tuse is left to forwarding.
- MDU stall: `stall_md` = md_D & (start_E | md_busy).
- `stall` = stall_rs | stall_rt | stall_md; `flush_E` = `stall`.
- MDU FSM, two states:
  - IDLE: `md_busy`=0. On `start_E`, load count = LAT_DIV if `is_div_E`, else LAT_MULT, and go to BUSY.
  - BUSY: `md_busy`=1, count decrements each cycle. At count==1 the next state is IDLE.
  - `start_E` while BUSY (protocol violation, prevented by `stall_md`) reloads the count with the new latency. This is the defined behaviour.
- `stall_cnt` increments on every cycle with `stall`=1 and holds at 32'hFFFF_FFFF.
- Register 0 never causes a stall, even when wa_E/wa_M are 0.

## Timing
- Reset (reset=0, async): FSM=IDLE, count=0, `md_busy`=0, `stall_cnt`=0. `stall`/`flush_E` then depend only on the data-hazard inputs.
- Deassertion is synchronous to `clk`; the first counted edge is the first rising edge with reset=1.
- `start_E` sampled at edge t with mult: `md_busy`=1 during cycles t+1..t+5, 0 from t+6.
- A `md_D` instruction stalls from the cycle `start_E` is high through the last busy cycle, and issues in cycle t+6 (div: t+11).
- Reset mid-BUSY clears immediately; a pending md_D stall drops in the same cycle.
- `stall` is a pure combinational function of current inputs and registered `md_busy`. There is no added latency.
- `stall_cnt` updates at the edge ending a stalled cycle.

## Structure
- Shared package `pipe_pkg`:
  - tuse/tnew encodings (`T_BRANCH`=0, `T_ALU`=1, `T_MEM`=2, `T_NONE`=3)
  - MDU state enum
  - default LAT_MULT/LAT_DIV constants
- One sub-module, `mdu_busy_ctr`, holds the FSM plus down-counter, with ports clk, reset, start, is_div, busy.
- Hazard compare logic and `stall_cnt` live in the top module.

## Test plan
- Load-use: wa_E=8, tnew_E=2, rs_D=8, tuse_rs_D=1 → `stall`=1, `flush_E`=1. Next cycle wa_M=8, tnew_M=1 → `stall`=0 (forwarded).
- Branch after ALU: wa_E=9, tnew_E=1, rt_D=9, tuse_rt_D=0 → `stall`=1. Same case with rt_D=0 and wa_E=0 → `stall`=0.
- mult at t, then mflo in D at t: `stall`=1 for cycles t..t+5, `md_busy` high t+1..t+5, mflo issues t+6.
- div with LAT_DIV=10: `md_busy` high exactly 10 cycles. A non-md instruction in D during busy → `stall`=0.
- Drop reset low at busy cycle 3 of a div → `md_busy`=0 and `stall`=0 immediately, `stall_cnt`=0. After release, mflo in D → no stall.
- Preload `stall_cnt` near saturation by forcing or a long run, then hold `stall`=1 → count sticks at 32'hFFFF_FFFF.
